msk_alu_sequencer: RTL and testbench

MSK_ALU_SEQUENCER -- requirements
Module: msk_alu_sequencer

---
 rtl/msk_alu_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_msk_alu_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_alu_sequencer.sv
// Sequencer for a two-share masked ALU.
// Accepts a request, obtains fresh randomness, holds the operands on the ALU
// for the whole execution, then returns the result shares. Data registers are
// wiped whenever an operation ends, so no share outlives its operation.
module msk_alu_sequencer #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [BIT_WIDTH-1:0] req_rs1_s0,
  input  logic [BIT_WIDTH-1:0] req_rs1_s1,
  input  logic [BIT_WIDTH-1:0] req_rs2_s0,
  input  logic [BIT_WIDTH-1:0] req_rs2_s1,
  output logic                 rnd_req,
  input  logic                 rnd_ack,
  output logic                 alu_valid,
  output logic                 alu_flush,
  output logic                 alu_op_add,
  output logic                 alu_op_sub,
  output logic                 alu_op_b2a,
  output logic [BIT_WIDTH-1:0] alu_rs1_s0,
  output logic [BIT_WIDTH-1:0] alu_rs1_s1,
  output logic [BIT_WIDTH-1:0] alu_rs2_s0,
  output logic [BIT_WIDTH-1:0] alu_rs2_s1,
  input  logic [BIT_WIDTH-1:0] alu_rd_s0,
  input  logic [BIT_WIDTH-1:0] alu_rd_s1,
  input  logic                 alu_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BIT_WIDTH-1:0] rsp_rd_s0,
  output logic [BIT_WIDTH-1:0] rsp_rd_s1,
  output logic                 rsp_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAND,
    ST_EXEC,
    ST_RESP,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_nxt;

  logic [1:0]           r_op;
  logic [BIT_WIDTH-1:0] r_rs1_s0;
  logic [BIT_WIDTH-1:0] r_rs1_s1;
  logic [BIT_WIDTH-1:0] r_rs2_s0;
  logic [BIT_WIDTH-1:0] r_rs2_s1;
  logic [BIT_WIDTH-1:0] r_rd_s0;
  logic [BIT_WIDTH-1:0] r_rd_s1;
  logic                 r_err;
  logic [7:0]           r_cnt;
  logic                 r_to;

  logic                 w_load;
  logic                 w_load_rsv;
  logic                 w_capture;
  logic                 w_timeout;
  logic                 w_clear;
  logic                 w_cnt_inc;
  logic                 w_opnd_vis;
  logic                 w_exec;
  logic                 w_resp;

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and datapath strobes; flush always takes priority.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_rsv  = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_clear     = 1'b0;
    w_cnt_inc   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          if (req_op == 2'b11) begin
            w_load_rsv  = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_RAND;
          end
        end
      end
      ST_RAND: begin
        if (flush) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else if (rnd_ack) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (flush) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else if (alu_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_timeout   = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      ST_RESP: begin
        if (flush) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else if (rsp_ready) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        w_clear     = 1'b1;
        w_state_nxt = r_to ? ST_RESP : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand, result, error, timeout-counter registers.
  // Operands are wiped already on result capture; they are not visible in RESP.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_op     <= '0;
      r_rs1_s0 <= '0;
      r_rs1_s1 <= '0;
      r_rs2_s0 <= '0;
      r_rs2_s1 <= '0;
      r_rd_s0  <= '0;
      r_rd_s1  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_to     <= 1'b0;
    end else begin
      if (w_load) begin
        r_op     <= req_op;
        r_rs1_s0 <= req_rs1_s0;
        r_rs1_s1 <= req_rs1_s1;
        r_rs2_s0 <= req_rs2_s0;
        r_rs2_s1 <= req_rs2_s1;
      end else if (w_clear || w_capture || w_load_rsv) begin
        r_op     <= '0;
        r_rs1_s0 <= '0;
        r_rs1_s1 <= '0;
        r_rs2_s0 <= '0;
        r_rs2_s1 <= '0;
      end

      if (w_capture) begin
        r_rd_s0 <= alu_rd_s0;
        r_rd_s1 <= alu_rd_s1;
      end else if (w_clear || w_load_rsv) begin
        r_rd_s0 <= '0;
        r_rd_s1 <= '0;
      end

      // A timed-out operation leaves DRAIN with an error response.
      if (w_load_rsv) begin
        r_err <= 1'b1;
      end else if (r_state == ST_DRAIN) begin
        r_err <= r_to;
      end else if (w_clear || w_load) begin
        r_err <= 1'b0;
      end

      r_cnt <= w_cnt_inc ? r_cnt + 8'd1 : '0;
      r_to  <= w_timeout;
    end
  end

  assign w_exec     = (r_state == ST_EXEC);
  assign w_resp     = (r_state == ST_RESP);
  assign w_opnd_vis = (r_state == ST_RAND) || w_exec;

  // req_ready is held low while reset is asserted so every output reads zero.
  assign req_ready  = g_resetn && (r_state == ST_IDLE) && !flush;
  assign rnd_req    = (r_state == ST_RAND);
  assign alu_valid  = w_exec;
  assign alu_flush  = (r_state == ST_DRAIN);
  assign alu_op_add = w_exec && (r_op == 2'b00);
  assign alu_op_sub = w_exec && (r_op == 2'b01);
  assign alu_op_b2a = w_exec && (r_op == 2'b10);

  assign alu_rs1_s0 = w_opnd_vis ? r_rs1_s0 : '0;
  assign alu_rs1_s1 = w_opnd_vis ? r_rs1_s1 : '0;
  assign alu_rs2_s0 = w_opnd_vis ? r_rs2_s0 : '0;
  assign alu_rs2_s1 = w_opnd_vis ? r_rs2_s1 : '0;

  assign rsp_valid  = w_resp;
  assign rsp_rd_s0  = w_resp ? r_rd_s0 : '0;
  assign rsp_rd_s1  = w_resp ? r_rd_s1 : '0;
  assign rsp_err    = w_resp && r_err;

endmodule

// File: tb/tb_msk_alu_sequencer.sv
// Self-checking bench for msk_alu_sequencer: directed corner cases plus
// randomized transactions checked against a transaction-level expectation.
module tb_msk_alu_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 8;

  logic         g_clk;
  logic         g_resetn;
  logic         flush;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_rs1_s0;
  logic [W-1:0] req_rs1_s1;
  logic [W-1:0] req_rs2_s0;
  logic [W-1:0] req_rs2_s1;
  logic         rnd_req;
  logic         rnd_ack;
  logic         alu_valid;
  logic         alu_flush;
  logic         alu_op_add;
  logic         alu_op_sub;
  logic         alu_op_b2a;
  logic [W-1:0] alu_rs1_s0;
  logic [W-1:0] alu_rs1_s1;
  logic [W-1:0] alu_rs2_s0;
  logic [W-1:0] alu_rs2_s1;
  logic [W-1:0] alu_rd_s0;
  logic [W-1:0] alu_rd_s1;
  logic         alu_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_rd_s0;
  logic [W-1:0] rsp_rd_s1;
  logic         rsp_err;

  int n_chk  = 0;
  int n_pass = 0;

  msk_alu_sequencer #(
    .BIT_WIDTH (W),
    .TIMEOUT   (TO)
  ) u_dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1_s0 (req_rs1_s0),
    .req_rs1_s1 (req_rs1_s1),
    .req_rs2_s0 (req_rs2_s0),
    .req_rs2_s1 (req_rs2_s1),
    .rnd_req    (rnd_req),
    .rnd_ack    (rnd_ack),
    .alu_valid  (alu_valid),
    .alu_flush  (alu_flush),
    .alu_op_add (alu_op_add),
    .alu_op_sub (alu_op_sub),
    .alu_op_b2a (alu_op_b2a),
    .alu_rs1_s0 (alu_rs1_s0),
    .alu_rs1_s1 (alu_rs1_s1),
    .alu_rs2_s0 (alu_rs2_s0),
    .alu_rs2_s1 (alu_rs2_s1),
    .alu_rd_s0  (alu_rd_s0),
    .alu_rd_s1  (alu_rd_s1),
    .alu_ready  (alu_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rd_s0  (rsp_rd_s0),
    .rsp_rd_s1  (rsp_rd_s1),
    .rsp_err    (rsp_err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cyc();
    @(posedge g_clk);
    #1;
  endtask

  // Outputs that must be zero in IDLE/DRAIN/RESP-like states.
  task automatic chk_no_opnd(input string tag);
    chk({tag, ".rs1_s0"}, 64'(alu_rs1_s0), 64'd0);
    chk({tag, ".rs1_s1"}, 64'(alu_rs1_s1), 64'd0);
    chk({tag, ".rs2_s0"}, 64'(alu_rs2_s0), 64'd0);
    chk({tag, ".rs2_s1"}, 64'(alu_rs2_s1), 64'd0);
  endtask

  task automatic chk_opnd(input string tag, input logic [W-1:0] a0, input logic [W-1:0] a1,
                          input logic [W-1:0] b0, input logic [W-1:0] b1);
    chk({tag, ".rs1_s0"}, 64'(alu_rs1_s0), 64'(a0));
    chk({tag, ".rs1_s1"}, 64'(alu_rs1_s1), 64'(a1));
    chk({tag, ".rs2_s0"}, 64'(alu_rs2_s0), 64'(b0));
    chk({tag, ".rs2_s1"}, 64'(alu_rs2_s1), 64'(b1));
  endtask

  // One complete transaction. ack_dly: RAND cycles before rnd_ack;
  // rdy_dly: EXEC cycle carrying alu_ready (>= TO means never);
  // rsp_dly: RESP cycles with rsp_ready low; r0/r1: shares the ALU returns.
  task automatic do_txn(input logic [1:0] op, input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [W-1:0] b0, input logic [W-1:0] b1, input int ack_dly,
                        input int rdy_dly, input int rsp_dly, input logic [W-1:0] r0,
                        input logic [W-1:0] r1);
    bit           rsv;
    bit           tmo;
    bit           exp_err;
    logic [W-1:0] exp_rd0;
    logic [W-1:0] exp_rd1;
    int           n_exec;
    rsv     = (op == 2'b11);
    tmo     = !rsv && (rdy_dly >= int'(TO));
    exp_err = rsv || tmo;
    exp_rd0 = exp_err ? '0 : r0;
    exp_rd1 = exp_err ? '0 : r1;
    n_exec  = tmo ? int'(TO) : rdy_dly + 1;

    req_valid  = 1'b1;
    req_op     = op;
    req_rs1_s0 = a0;
    req_rs1_s1 = a1;
    req_rs2_s0 = b0;
    req_rs2_s1 = b1;
    @(negedge g_clk);
    chk("accept.req_ready", 64'(req_ready), 64'd1);
    next_cyc();
    req_valid  = 1'b0;
    req_op     = 2'($urandom);
    req_rs1_s0 = $urandom;
    req_rs1_s1 = $urandom;
    req_rs2_s0 = $urandom;
    req_rs2_s1 = $urandom;

    if (!rsv) begin
      for (int i = 0; i <= ack_dly; i++) begin
        rnd_ack   = (i == ack_dly);
        alu_ready = 1'b1;
        alu_rd_s0 = $urandom;
        alu_rd_s1 = $urandom;
        @(negedge g_clk);
        chk("rand.rnd_req", 64'(rnd_req), 64'd1);
        chk("rand.alu_valid", 64'(alu_valid), 64'd0);
        chk("rand.req_ready", 64'(req_ready), 64'd0);
        chk_opnd("rand", a0, a1, b0, b1);
        next_cyc();
      end
      rnd_ack = 1'b0;
      for (int i = 0; i < n_exec; i++) begin
        alu_ready = (i == rdy_dly);
        alu_rd_s0 = (i == rdy_dly) ? r0 : W'($urandom);
        alu_rd_s1 = (i == rdy_dly) ? r1 : W'($urandom);
        @(negedge g_clk);
        chk("exec.alu_valid", 64'(alu_valid), 64'd1);
        chk("exec.op", 64'({alu_op_add, alu_op_sub, alu_op_b2a}),
            64'({op == 2'b00, op == 2'b01, op == 2'b10}));
        chk("exec.rnd_req", 64'(rnd_req), 64'd0);
        chk("exec.rsp_valid", 64'(rsp_valid), 64'd0);
        chk_opnd("exec", a0, a1, b0, b1);
        next_cyc();
      end
      alu_ready = 1'b0;
      if (tmo) begin
        alu_ready = 1'b1;
        alu_rd_s0 = $urandom;
        alu_rd_s1 = $urandom;
        @(negedge g_clk);
        chk("tmo.alu_flush", 64'(alu_flush), 64'd1);
        chk("tmo.alu_valid", 64'(alu_valid), 64'd0);
        chk("tmo.rsp_valid", 64'(rsp_valid), 64'd0);
        chk_no_opnd("tmo");
        next_cyc();
      end
    end

    for (int i = 0; i <= rsp_dly; i++) begin
      rsp_ready = (i == rsp_dly);
      alu_ready = 1'b1;
      alu_rd_s0 = $urandom;
      alu_rd_s1 = $urandom;
      @(negedge g_clk);
      chk("resp.rsp_valid", 64'(rsp_valid), 64'd1);
      chk("resp.rsp_err", 64'(rsp_err), 64'(exp_err));
      chk("resp.rd_s0", 64'(rsp_rd_s0), 64'(exp_rd0));
      chk("resp.rd_s1", 64'(rsp_rd_s1), 64'(exp_rd1));
      chk("resp.alu_valid", 64'(alu_valid), 64'd0);
      chk("resp.alu_flush", 64'(alu_flush), 64'd0);
      chk("resp.rnd_req", 64'(rnd_req), 64'd0);
      chk("resp.req_ready", 64'(req_ready), 64'd0);
      chk_no_opnd("resp");
      next_cyc();
    end
    rsp_ready = 1'b0;
    alu_ready = 1'b0;
    @(negedge g_clk);
    chk("done.req_ready", 64'(req_ready), 64'd1);
    chk("done.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("done.rd", 64'({rsp_rd_s0, rsp_rd_s1}), 64'd0);
    chk("done.rnd_req", 64'(rnd_req), 64'd0);
    chk_no_opnd("done");
    next_cyc();
  endtask

  // Flush raised in RAND (with rnd_ack), EXEC (with alu_ready) or RESP (with rsp_ready).
  task automatic flush_case(input int where);
    req_valid  = 1'b1;
    req_op     = 2'($urandom_range(0, 2));
    req_rs1_s0 = $urandom | 32'h1;
    req_rs1_s1 = $urandom | 32'h1;
    req_rs2_s0 = $urandom | 32'h1;
    req_rs2_s1 = $urandom | 32'h1;
    @(negedge g_clk);
    chk("fl.accept", 64'(req_ready), 64'd1);
    next_cyc();
    req_valid = 1'b0;
    rnd_ack   = 1'b1;
    if (where == 0) flush = 1'b1;
    @(negedge g_clk);
    chk("fl.rand", 64'(rnd_req), 64'd1);
    next_cyc();
    rnd_ack = 1'b0;
    if (where >= 1) begin
      alu_ready = 1'b1;
      alu_rd_s0 = $urandom | 32'h1;
      alu_rd_s1 = $urandom | 32'h1;
      if (where == 1) flush = 1'b1;
      @(negedge g_clk);
      chk("fl.exec", 64'(alu_valid), 64'd1);
      next_cyc();
      alu_ready = 1'b0;
      if (where == 2) begin
        flush     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge g_clk);
        chk("fl.resp", 64'(rsp_valid), 64'd1);
        next_cyc();
        rsp_ready = 1'b0;
      end
    end
    flush = 1'b0;
    @(negedge g_clk);
    chk("fl.drain.alu_flush", 64'(alu_flush), 64'd1);
    chk("fl.drain.alu_valid", 64'(alu_valid), 64'd0);
    chk("fl.drain.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("fl.drain.rnd_req", 64'(rnd_req), 64'd0);
    chk("fl.drain.req_ready", 64'(req_ready), 64'd0);
    chk_no_opnd("fl.drain");
    next_cyc();
    @(negedge g_clk);
    chk("fl.idle.req_ready", 64'(req_ready), 64'd1);
    chk("fl.idle.alu_flush", 64'(alu_flush), 64'd0);
    chk("fl.idle.rsp_valid", 64'(rsp_valid), 64'd0);
    next_cyc();
  endtask

  task automatic reset_in_exec();
    req_valid  = 1'b1;
    req_op     = 2'b01;
    req_rs1_s0 = 32'hA5A5_0001;
    req_rs1_s1 = 32'h5A5A_0002;
    req_rs2_s0 = 32'h1234_0003;
    req_rs2_s1 = 32'h4321_0004;
    @(negedge g_clk);
    next_cyc();
    req_valid = 1'b0;
    rnd_ack   = 1'b1;
    @(negedge g_clk);
    next_cyc();
    rnd_ack = 1'b0;
    @(negedge g_clk);
    chk("rst.exec", 64'(alu_valid), 64'd1);
    #2;
    g_resetn = 1'b0;
    #1;
    chk("rst.alu_valid", 64'(alu_valid), 64'd0);
    chk("rst.alu_op", 64'({alu_op_add, alu_op_sub, alu_op_b2a}), 64'd0);
    chk("rst.alu_flush", 64'(alu_flush), 64'd0);
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk_no_opnd("rst");
    next_cyc();
    chk("rst.hold.alu_flush", 64'(alu_flush), 64'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    #1;
    chk("rst.rel.req_ready", 64'(req_ready), 64'd1);
    next_cyc();
    @(negedge g_clk);
    chk("rst.after.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst.after.alu_flush", 64'(alu_flush), 64'd0);
    next_cyc();
  endtask

  initial begin
    g_resetn   = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = '0;
    req_rs1_s0 = '0;
    req_rs1_s1 = '0;
    req_rs2_s0 = '0;
    req_rs2_s1 = '0;
    rnd_ack    = 1'b0;
    alu_rd_s0  = '0;
    alu_rd_s1  = '0;
    alu_ready  = 1'b0;
    rsp_ready  = 1'b0;

    #3;
    chk("reset.outputs", 64'({req_ready, rnd_req, alu_valid, alu_flush, alu_op_add,
                              alu_op_sub, alu_op_b2a, rsp_valid, rsp_err}), 64'd0);
    chk("reset.rsp_rd", 64'({rsp_rd_s0, rsp_rd_s1}), 64'd0);
    chk_no_opnd("reset");
    @(posedge g_clk);
    @(negedge g_clk);
    g_resetn = 1'b1;
    #1;
    chk("reset.rel.req_ready", 64'(req_ready), 64'd1);
    next_cyc();

    // Flush in IDLE blocks acceptance.
    flush     = 1'b1;
    req_valid = 1'b1;
    @(negedge g_clk);
    chk("idle_flush.req_ready", 64'(req_ready), 64'd0);
    next_cyc();
    flush     = 1'b0;
    req_valid = 1'b0;
    @(negedge g_clk);
    chk("idle_flush.rnd_req", 64'(rnd_req), 64'd0);
    chk("idle_flush.req_ready", 64'(req_ready), 64'd1);
    next_cyc();

    // Basic add with ack after 2 cycles, alu_ready after 4.
    do_txn(2'b00, 32'h5, 32'h3, 32'h1, 32'h0, 2, 4, 0, 32'h0000_0007, 32'h0000_0002);
    // Reserved op.
    do_txn(2'b11, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 32'h0, 32'h0);
    // b2a that never completes.
    do_txn(2'b10, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0, 32'h0, 1, int'(TO) + 5, 0,
           32'h0, 32'h0);
    // Response back-pressure.
    do_txn(2'b01, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 32'hCAFE_0004, 0, 0, 5,
           32'h1357_9BDF, 32'h2468_ACE0);
    // Completion on the last EXEC cycle before timeout.
    do_txn(2'b00, 32'h1, 32'h2, 32'h3, 32'h4, 0, int'(TO) - 1, 1, 32'hAAAA_5555, 32'h5555_AAAA);

    flush_case(0);
    flush_case(1);
    flush_case(2);
    reset_in_exec();
    do_txn(2'b00, 32'h9, 32'h8, 32'h7, 32'h6, 0, 1, 0, 32'h0F0F_0F0F, 32'hF0F0_F0F0);

    for (int t = 0; t < 40; t++) begin
      do_txn(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 2)),
             int'($urandom_range(0, 3)), $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
